any1_vagen: RTL and testbench

ANY1_VAGEN -- requirements
Module: any1_vagen

---
 rtl/any1_pkg.sv | 14 +
 rtl/any1_vagen.sv | 214 +++++++++++++++++++++
 tb/tb_any1_vagen.sv | 341 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/any1_pkg.sv
// Shared definitions for the ANY1 address-generation path: request modes and
// the default address width.
package any1_pkg;

    localparam int ANY1_AWID = 64;

    typedef enum logic [1:0] {
        SCALAR = 2'd0,
        SINDEX = 2'd1,
        STRIDE = 2'd2,
        VINDEX = 2'd3
    } agen_mode_t;

endpackage

// File: rtl/any1_vagen.sv
// Vector address generator: turns one scalar, indexed or strided request into
// a stream of effective addresses, one per enabled element.
module any1_vagen
    import any1_pkg::*;
#(
    parameter int  AWID  = ANY1_AWID,
    parameter int  VLMAX = 64,
    localparam int VLW   = $clog2(VLMAX + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             abort,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [1:0]       req_mode,
    input  logic [AWID-1:0]  req_base,
    input  logic [AWID-1:0]  req_imm,
    input  logic [AWID-1:0]  req_stride,
    input  logic [2:0]       req_sc,
    input  logic [VLW-1:0]   req_vl,
    input  logic [VLMAX-1:0] req_mask,
    input  logic             idx_valid,
    input  logic [AWID-1:0]  idx,
    output logic             idx_ready,
    output logic             ea_valid,
    input  logic             ea_ready,
    output logic [AWID-1:0]  ea,
    output logic [VLW-1:0]   ea_elem,
    output logic             ea_last,
    output logic             busy,
    output logic             done
);

    typedef enum logic [1:0] {ST_IDLE, ST_FETCH, ST_EMIT, ST_DONE} state_t;

    state_t           state_q, state_d;
    agen_mode_t       mode_q, mode_d;
    logic [AWID-1:0]  base_imm_q, base_imm_d;
    logic [AWID-1:0]  acc_q, acc_d;
    logic [AWID-1:0]  stride_q, stride_d;
    logic [2:0]       sc_q, sc_d;
    logic [VLW-1:0]   vl_q, vl_d;
    logic [VLMAX-1:0] mask_q, mask_d;
    logic [VLW-1:0]   elem_q, elem_d;
    logic [AWID-1:0]  ea_q, ea_d;
    logic [VLW-1:0]   ea_elem_q, ea_elem_d;
    logic             ea_last_q, ea_last_d;
    logic             ea_valid_q, ea_valid_d;
    logic             done_q, done_d;

    logic [VLW-1:0]   vl_clamp;
    logic [VLMAX-1:0] vl_window;
    logic [AWID-1:0]  idx_ea;
    logic             elems_left;
    logic             cur_last;
    logic             advance;

    assign req_ready  = (state_q == ST_IDLE) && !rst;
    assign busy       = (state_q != ST_IDLE);
    assign done       = done_q;
    assign ea_valid   = ea_valid_q;
    assign ea         = ea_q;
    assign ea_elem    = ea_elem_q;
    assign ea_last    = ea_last_q;

    // mask_q shifts right as elements retire, so bit 0 is always the current element.
    assign elems_left = (elem_q != vl_q);
    assign cur_last   = ((mask_q >> 1) == '0);
    assign idx_ea     = base_imm_q + (idx << sc_q);
    assign idx_ready  = !rst && (state_q == ST_FETCH) &&
                        ((mode_q == SINDEX) || ((mode_q == VINDEX) && elems_left));

    always_comb begin
        vl_window = '0;
        vl_clamp  = (req_vl > VLW'(VLMAX)) ? VLW'(VLMAX) : req_vl;
        for (int i = 0; i < VLMAX; i++) begin
            vl_window[i] = (i < int'(vl_clamp));
        end
    end

    always_comb begin
        // NOTE: every _d starts from its _q so no path through this block can infer a latch.
        state_d    = state_q;
        mode_d     = mode_q;
        base_imm_d = base_imm_q;
        acc_d      = acc_q;
        stride_d   = stride_q;
        sc_d       = sc_q;
        vl_d       = vl_q;
        mask_d     = mask_q;
        elem_d     = elem_q;
        ea_d       = ea_q;
        ea_elem_d  = ea_elem_q;
        ea_last_d  = ea_last_q;
        ea_valid_d = ea_valid_q;
        advance    = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (req_valid && req_ready) begin
                    mode_d     = agen_mode_t'(req_mode);
                    base_imm_d = req_base + req_imm;
                    acc_d      = req_base + req_imm;
                    stride_d   = req_stride;
                    sc_d       = req_sc;
                    vl_d       = vl_clamp;
                    mask_d     = req_mask & vl_window;
                    elem_d     = '0;
                    state_d    = ST_FETCH;
                end
            end
            ST_FETCH: begin
                case (mode_q)
                    SCALAR: begin
                        ea_d       = base_imm_q;
                        ea_elem_d  = '0;
                        ea_last_d  = 1'b1;
                        ea_valid_d = 1'b1;
                        state_d    = ST_EMIT;
                    end
                    SINDEX: begin
                        if (idx_valid) begin
                            ea_d       = idx_ea;
                            ea_elem_d  = '0;
                            ea_last_d  = 1'b1;
                            ea_valid_d = 1'b1;
                            state_d    = ST_EMIT;
                        end
                    end
                    default: begin
                        if (!elems_left) begin
                            state_d = ST_DONE;
                        end else if ((mode_q == STRIDE) || idx_valid) begin
                            if (mask_q[0]) begin
                                ea_d       = (mode_q == STRIDE) ? acc_q : idx_ea;
                                ea_elem_d  = elem_q;
                                ea_last_d  = cur_last;
                                ea_valid_d = 1'b1;
                                state_d    = ST_EMIT;
                            end else begin
                                advance = 1'b1;
                            end
                        end
                    end
                endcase
            end
            ST_EMIT: begin
                if (ea_ready) begin
                    ea_valid_d = 1'b0;
                    if ((mode_q == SCALAR) || (mode_q == SINDEX)) begin
                        state_d = ST_DONE;
                    end else begin
                        advance = 1'b1;
                        state_d = ST_FETCH;
                    end
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase

        // Stride addresses come from a running sum, never from e*stride.
        if (advance) begin
            acc_d  = acc_q + stride_q;
            elem_d = elem_q + VLW'(1);
            mask_d = mask_q >> 1;
        end

        done_d = (state_d == ST_DONE);

        // Abort wins over any handshake in the same cycle, including a pending ea transfer.
        if (abort) begin
            state_d    = ST_IDLE;
            ea_valid_d = 1'b0;
            done_d     = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: state is updated with non-blocking assignments so every flop samples pre-edge values.
        if (rst) begin
            state_q    <= ST_IDLE;
            mode_q     <= SCALAR;
            base_imm_q <= '0;
            acc_q      <= '0;
            stride_q   <= '0;
            sc_q       <= '0;
            vl_q       <= '0;
            mask_q     <= '0;
            elem_q     <= '0;
            ea_q       <= '0;
            ea_elem_q  <= '0;
            ea_last_q  <= 1'b0;
            ea_valid_q <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            mode_q     <= mode_d;
            base_imm_q <= base_imm_d;
            acc_q      <= acc_d;
            stride_q   <= stride_d;
            sc_q       <= sc_d;
            vl_q       <= vl_d;
            mask_q     <= mask_d;
            elem_q     <= elem_d;
            ea_q       <= ea_d;
            ea_elem_q  <= ea_elem_d;
            ea_last_q  <= ea_last_d;
            ea_valid_q <= ea_valid_d;
            done_q     <= done_d;
        end
    end

endmodule

// File: tb/tb_any1_vagen.sv
// Scoreboard bench for any1_vagen: a request-level model queues expected
// addresses; a negedge monitor compares every presented ea against the queue.
module tb_any1_vagen;
    import any1_pkg::*;

    localparam int AWID  = 64;
    localparam int VLMAX = 64;
    localparam int VLW   = $clog2(VLMAX + 1);

    typedef struct {
        logic [AWID-1:0] ea;
        int              elem;
        bit              last;
    } exp_t;

    logic             clk = 1'b0;
    logic             rst;
    logic             abort;
    logic             req_valid;
    logic             req_ready;
    logic [1:0]       req_mode;
    logic [AWID-1:0]  req_base;
    logic [AWID-1:0]  req_imm;
    logic [AWID-1:0]  req_stride;
    logic [2:0]       req_sc;
    logic [VLW-1:0]   req_vl;
    logic [VLMAX-1:0] req_mask;
    logic             idx_valid;
    logic [AWID-1:0]  idx;
    logic             idx_ready;
    logic             ea_valid;
    logic             ea_ready;
    logic [AWID-1:0]  ea;
    logic [VLW-1:0]   ea_elem;
    logic             ea_last;
    logic             busy;
    logic             done;

    always #5 clk = ~clk;

    any1_vagen #(.AWID(AWID), .VLMAX(VLMAX)) dut (
        .clk(clk), .rst(rst), .abort(abort),
        .req_valid(req_valid), .req_ready(req_ready), .req_mode(req_mode),
        .req_base(req_base), .req_imm(req_imm), .req_stride(req_stride),
        .req_sc(req_sc), .req_vl(req_vl), .req_mask(req_mask),
        .idx_valid(idx_valid), .idx(idx), .idx_ready(idx_ready),
        .ea_valid(ea_valid), .ea_ready(ea_ready), .ea(ea),
        .ea_elem(ea_elem), .ea_last(ea_last), .busy(busy), .done(done)
    );

    exp_t            exp_q[$];
    logic [AWID-1:0] idx_src[$];
    logic [AWID-1:0] dir_idx[$];

    int n_checks  = 0;
    int n_errors  = 0;
    int done_cnt  = 0;
    int exp_done  = 0;
    int idx_cnt   = 0;
    int pop_cnt   = 0;
    int stall_cnt = 0;
    bit rnd_ready = 1'b0;
    bit bp_arm    = 1'b0;
    bit bp_done   = 1'b0;
    int bp_hold   = 0;

    task automatic check(input string name, input logic [AWID-1:0] got, input logic [AWID-1:0] expv);
        n_checks++;
        if (got !== expv) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, got, expv);
        end
    endtask

    function automatic logic [AWID-1:0] next_idx();
        if (dir_idx.size() > 0) return dir_idx.pop_front();
        return {$urandom, $urandom};
    endfunction

    // Monitor: sample half a cycle away from the active edge.
    always @(negedge clk) begin
        if (!rst) begin
            if (ea_valid) begin
                if (exp_q.size() == 0) begin
                    check("ea_unexpected", ea_valid, 0);
                end else begin
                    check("ea", ea, exp_q[0].ea);
                    check("ea_elem", AWID'(ea_elem), AWID'(exp_q[0].elem));
                    check("ea_last", AWID'(ea_last), AWID'(exp_q[0].last));
                    if (!ea_ready) begin
                        stall_cnt++;
                    end else if (!abort) begin
                        void'(exp_q.pop_front());
                        pop_cnt++;
                    end
                end
            end
            if (done) begin
                done_cnt++;
                check("done_queue_empty", AWID'(exp_q.size()), 0);
            end
            if (idx_valid && idx_ready && !abort) begin
                if (idx_src.size() > 0) void'(idx_src.pop_front());
                idx_cnt++;
            end
        end
    end

    // Index source and ea_ready driver.
    initial begin
        idx_valid = 1'b0;
        idx       = '0;
        ea_ready  = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            if (idx_src.size() > 0 && (!rnd_ready || $urandom_range(0, 3) != 0)) begin
                idx_valid = 1'b1;
                idx       = idx_src[0];
            end else begin
                idx_valid = 1'b0;
                idx       = '0;
            end
            if (bp_hold > 0) begin
                ea_ready = 1'b0;
                bp_hold--;
            end else if (bp_arm && !bp_done && ea_valid && ea_elem == VLW'(1)) begin
                ea_ready = 1'b0;
                bp_hold  = 2;
                bp_done  = 1'b1;
            end else begin
                ea_ready = rnd_ready ? ($urandom_range(0, 2) != 0) : 1'b1;
            end
        end
    end

    // Reference model: enumerate elements, push the expected addresses, then offer the request.
    task automatic issue_req(input agen_mode_t mode, input logic [AWID-1:0] base,
                             input logic [AWID-1:0] imm, input logic [AWID-1:0] stride,
                             input logic [2:0] sc, input logic [VLW-1:0] vl,
                             input logic [VLMAX-1:0] mask, output int n_idx);
        int              vl_eff;
        int              last_e;
        int              t;
        logic [AWID-1:0] ix;
        logic [AWID-1:0] addr;
        vl_eff = (int'(vl) > VLMAX) ? VLMAX : int'(vl);
        n_idx  = 0;
        ix     = '0;
        if (mode == SCALAR) begin
            addr = base + imm;
            exp_q.push_back('{ea: addr, elem: 0, last: 1'b1});
        end else if (mode == SINDEX) begin
            ix = next_idx();
            idx_src.push_back(ix);
            n_idx = 1;
            addr  = base + imm + (ix << sc);
            exp_q.push_back('{ea: addr, elem: 0, last: 1'b1});
        end else begin
            last_e = -1;
            for (int e = 0; e < vl_eff; e++) if (mask[e]) last_e = e;
            for (int e = 0; e < vl_eff; e++) begin
                if (mode == VINDEX) begin
                    ix = next_idx();
                    idx_src.push_back(ix);
                    n_idx++;
                end
                if (mask[e]) begin
                    if (mode == STRIDE) addr = base + imm + AWID'(e) * stride;
                    else                addr = base + imm + (ix << sc);
                    exp_q.push_back('{ea: addr, elem: e, last: (e == last_e)});
                end
            end
        end
        @(posedge clk);
        #1;
        req_mode   = mode;
        req_base   = base;
        req_imm    = imm;
        req_stride = stride;
        req_sc     = sc;
        req_vl     = vl;
        req_mask   = mask;
        req_valid  = 1'b1;
        t = 0;
        @(negedge clk);
        while (!req_ready && t < 50) begin
            @(negedge clk);
            t++;
        end
        check("req_accepted", req_ready, 1);
        @(posedge clk);
        #1;
        req_valid = 1'b0;
    endtask

    task automatic wait_done(input string name, input int n_idx, input int idx0);
        int t = 0;
        exp_done++;
        while (done_cnt < exp_done && t < 3000) begin
            @(posedge clk);
            t++;
        end
        check({name, "_done"}, done_cnt, exp_done);
        check({name, "_idx_used"}, idx_cnt - idx0, n_idx);
        check({name, "_exp_drained"}, exp_q.size(), 0);
        exp_done = done_cnt;
        #1;
        check({name, "_req_ready"}, req_ready, 1);
        check({name, "_busy"}, busy, 0);
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int              n;
        int              i0;
        int              d0;
        int              p0;
        int              s0;
        int              t;
        agen_mode_t      m;
        logic [VLMAX-1:0] mk;
        logic [VLW-1:0]  vl;

        rst = 1'b1; abort = 1'b0; req_valid = 1'b0; req_mode = '0;
        req_base = '0; req_imm = '0; req_stride = '0; req_sc = '0; req_vl = '0; req_mask = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_req_ready", req_ready, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_ea_valid", ea_valid, 0);
        check("rst_idx_ready", idx_ready, 0);
        check("rst_ea", ea, 0);
        check("rst_ea_elem", AWID'(ea_elem), 0);
        check("rst_ea_last", ea_last, 0);
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("ready_after_reset", req_ready, 1);

        i0 = idx_cnt; issue_req(SCALAR, 64'h1000, 64'h10, 64'h0, 3'd0, 7'd5, '1, n);
        wait_done("scalar", n, i0);

        i0 = idx_cnt; issue_req(STRIDE, 64'h2000, 64'h0, 64'h8, 3'd0, 7'd4, 64'b1011, n);
        wait_done("stride", n, i0);

        dir_idx = '{64'd1, 64'd5, 64'd2};
        i0 = idx_cnt; issue_req(VINDEX, 64'h100, 64'h0, 64'h0, 3'd2, 7'd3, 64'b101, n);
        wait_done("vindex", n, i0);

        dir_idx = '{64'hF000_0000_0000_0003};
        i0 = idx_cnt; issue_req(SINDEX, 64'h40, 64'h4, 64'h0, 3'd7, 7'd0, '0, n);
        wait_done("sindex_ovf", n, i0);

        bp_arm = 1'b1; bp_done = 1'b0; s0 = stall_cnt;
        i0 = idx_cnt; issue_req(STRIDE, 64'h4000, 64'h0, 64'h4, 3'd0, 7'd4, 64'hF, n);
        wait_done("backpressure", n, i0);
        bp_arm = 1'b0;
        check("bp_stall_cycles", stall_cnt - s0, 3);

        i0 = idx_cnt; issue_req(STRIDE, 64'hFFFF_FFFF_FFFF_FFF8, 64'h0, 64'h8, 3'd0, 7'd2, 64'h3, n);
        wait_done("wrap", n, i0);

        i0 = idx_cnt; issue_req(STRIDE, 64'h8000, 64'h2, 64'h10, 3'd0, 7'd70, '1, n);
        wait_done("vl_clamp", n, i0);

        i0 = idx_cnt; issue_req(VINDEX, 64'h9000, 64'h0, 64'h0, 3'd1, 7'd5, '0, n);
        wait_done("mask_zero", n, i0);

        p0 = pop_cnt;
        issue_req(STRIDE, 64'h3000, 64'h0, 64'h10, 3'd0, 7'd8, 64'hFF, n);
        t = 0;
        while (pop_cnt < p0 + 2 && t < 200) begin
            @(posedge clk);
            t++;
        end
        check("abort_reached_elem2", pop_cnt - p0, 2);
        #1 abort = 1'b1;
        @(posedge clk);
        #1 abort = 1'b0;
        check("abort_busy", busy, 0);
        check("abort_ea_valid", ea_valid, 0);
        check("abort_idx_ready", idx_ready, 0);
        check("abort_done", done, 0);
        exp_q.delete();
        d0 = done_cnt;
        repeat (3) @(posedge clk);
        check("abort_no_done", done_cnt - d0, 0);
        i0 = idx_cnt; issue_req(STRIDE, 64'h5000, 64'h0, 64'h8, 3'd0, 7'd0, 64'hFF, n);
        wait_done("vl_zero", n, i0);

        p0 = pop_cnt;
        issue_req(VINDEX, 64'h6000, 64'h8, 64'h0, 3'd3, 7'd8, 64'hFF, n);
        t = 0;
        while (pop_cnt < p0 + 3 && t < 200) begin
            @(posedge clk);
            t++;
        end
        #1 rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        exp_q.delete();
        idx_src.delete();
        @(negedge clk);
        check("midrst_busy", busy, 0);
        check("midrst_ea_valid", ea_valid, 0);
        check("midrst_ea", ea, 0);
        check("midrst_req_ready", req_ready, 0);
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("midrst_ready_after", req_ready, 1);
        i0 = idx_cnt; issue_req(SCALAR, 64'hABC0, 64'h4, 64'h0, 3'd0, 7'd9, '0, n);
        wait_done("after_reset", n, i0);

        rnd_ready = 1'b1;
        for (int k = 0; k < 80; k++) begin
            m = agen_mode_t'($urandom_range(0, 3));
            case ($urandom_range(0, 3))
                0:       mk = '0;
                1:       mk = '1;
                default: mk = {$urandom, $urandom};
            endcase
            vl = VLW'($urandom_range(0, VLMAX + 4));
            i0 = idx_cnt;
            issue_req(m, {$urandom, $urandom}, {$urandom, $urandom}, {$urandom, $urandom},
                      3'($urandom_range(0, 7)), vl, mk, n);
            wait_done("rand", n, i0);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
